// File: rtl/execute_unit.sv
// Execute stage: operand inversion, 16-bit ALU with flags, branch condition,
// PC target adder and the registered result/PC outputs.
module execute_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inA,
    input  logic [15:0] inB,
    input  logic        invA,
    input  logic        invB,
    input  logic        Cin,
    input  logic [3:0]  aluOp,
    input  logic [2:0]  brchSig,
    input  logic [15:0] incPC,
    input  logic [15:0] imm8,
    input  logic [15:0] imm11,
    input  logic        immSrc,
    input  logic        SLBIsel,
    input  logic        aluJmp,
    input  logic        jalSel,
    input  logic        sOpSel,
    output logic [15:0] aluOut,
    output logic [15:0] aluFinal,
    output logic [15:0] newPC,
    output logic [15:0] addPC
);

    localparam int unsigned W     = 16;
    localparam int unsigned SHW   = 4;
    localparam int unsigned HALFW = W / 2;

    localparam logic [3:0] OP_ROL  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_ROR  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_PASB = 4'b1000;
    localparam logic [3:0] OP_CAT  = 4'b1001;
    localparam logic [3:0] OP_BREV = 4'b1010;

    logic [W-1:0]   opnd_a;
    logic [W-1:0]   opnd_b;
    logic [SHW-1:0] shamt;
    logic [SHW:0]   shamt_inv;
    logic [W-1:0]   rot_l;
    logic [W-1:0]   rot_r;
    logic [W-1:0]   bit_rev;
    logic [W-1:0]   add_sum;
    logic           add_cout;
    logic           add_ovf;
    logic [W-1:0]   result;
    logic           is_add;
    logic           zf;
    logic           sf;
    logic           of;
    logic           cf;
    logic           cond;
    logic [W-1:0]   pc_base;
    logic [W-1:0]   pc_disp;
    logic [W-1:0]   comp_pc;
    logic           pc_cout_unused;
    logic           pc_ovf_unused;
    logic [W-1:0]   jmp_pc;
    logic [W-1:0]   add_pc_d;
    logic [W-1:0]   new_pc_d;
    logic [W-1:0]   alu_final_d;

    assign opnd_a = invA ? ~inA : inA;
    assign opnd_b = invB ? ~inB : inB;
    assign shamt  = opnd_b[SHW-1:0];

    // Shifting by W (amount 0) yields zero, so the rotates degenerate cleanly.
    assign shamt_inv = (SHW+1)'(W) - (SHW+1)'(shamt);
    assign rot_l     = (opnd_a << shamt) | (opnd_a >> shamt_inv);
    assign rot_r     = (opnd_a >> shamt) | (opnd_a << shamt_inv);

    always_comb begin
        bit_rev = '0;
        for (int i = 0; i < int'(W); i++) begin
            bit_rev[i] = opnd_a[int'(W) - 1 - i];
        end
    end

    execute_unit_cla16 u_alu_add (
        .a    (opnd_b == opnd_b ? opnd_a : opnd_a),
        .b    (opnd_b),
        .cin  (Cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // ALU result mux
    always_comb begin
        result = opnd_a;
        case (aluOp)
            OP_ROL:  result = rot_l;
            OP_SLL:  result = opnd_a << shamt;
            OP_ROR:  result = rot_r;
            OP_SRL:  result = opnd_a >> shamt;
            OP_ADD:  result = add_sum;
            OP_AND:  result = opnd_a & opnd_b;
            OP_OR:   result = opnd_a | opnd_b;
            OP_XOR:  result = opnd_a ^ opnd_b;
            OP_PASB: result = opnd_b;
            OP_CAT:  result = {opnd_a[HALFW-1:0], opnd_b[HALFW-1:0]};
            OP_BREV: result = bit_rev;
            default: result = opnd_a;
        endcase
    end

    assign is_add = (aluOp == OP_ADD);
    assign zf     = (result == '0);
    assign sf     = result[W-1];
    assign of     = is_add & add_ovf;
    assign cf     = is_add & add_cout;

    // Branch / set condition select
    always_comb begin
        cond = 1'b0;
        case (brchSig)
            3'b000:  cond = 1'b0;
            3'b001:  cond = zf;
            3'b010:  cond = ~zf;
            3'b011:  cond = sf;
            3'b100:  cond = ~sf;
            3'b101:  cond = sf ^ of;
            3'b110:  cond = (sf ^ of) | zf;
            3'b111:  cond = cf;
            default: cond = 1'b0;
        endcase
    end

    assign pc_base = SLBIsel ? result : incPC;
    assign pc_disp = immSrc ? imm11 : imm8;

    execute_unit_cla16 u_pc_add (
        .a    (pc_base),
        .b    (pc_disp),
        .cin  (1'b0),
        .sum  (comp_pc),
        .cout (pc_cout_unused),
        .ovf  (pc_ovf_unused)
    );

    assign jmp_pc      = cond ? comp_pc : incPC;
    assign add_pc_d    = jalSel ? incPC : jmp_pc;
    assign new_pc_d    = SLBIsel ? incPC : (aluJmp ? result : jmp_pc);
    assign alu_final_d = sOpSel ? {{(W-1){1'b0}}, cond} : result;

    // Output registers: one cycle of latency, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluOut   <= '0;
            aluFinal <= '0;
            newPC    <= '0;
            addPC    <= '0;
        end else begin
            aluOut   <= result;
            aluFinal <= alu_final_d;
            newPC    <= new_pc_d;
            addPC    <= add_pc_d;
        end
    end

endmodule

// 16-bit adder: four 4-bit CLA groups joined by a second-level lookahead.
module execute_unit_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);

    logic [3:0] gg;
    logic [3:0] gp;
    logic [3:0] gc;

    for (genvar i = 0; i < 4; i++) begin : g_grp
        execute_unit_cla4 u_grp (
            .a   (a[4*i +: 4]),
            .b   (b[4*i +: 4]),
            .cin (gc[i]),
            .sum (sum[4*i +: 4]),
            .gg  (gg[i]),
            .gp  (gp[i])
        );
    end

    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    // Signed overflow: like-signed operands producing an opposite-signed sum
    assign ovf = ~(a[15] ^ b[15]) & (sum[15] ^ a[15]);

endmodule

// 4-bit carry-lookahead group with group generate/propagate outputs.
module execute_unit_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       gg,
    output logic       gp
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
    assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
    assign gp  = &p;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: behavioural reference model checked
// every cycle, plus hand-computed literal expectations for directed vectors.
module tb_execute_unit;

    typedef struct packed {
        logic [15:0] inA;
        logic [15:0] inB;
        logic        invA;
        logic        invB;
        logic        Cin;
        logic [3:0]  aluOp;
        logic [2:0]  brchSig;
        logic [15:0] incPC;
        logic [15:0] imm8;
        logic [15:0] imm11;
        logic        immSrc;
        logic        SLBIsel;
        logic        aluJmp;
        logic        jalSel;
        logic        sOpSel;
    } vec_t;

    logic        clk;
    logic        rst;
    vec_t        cur;
    logic [15:0] aluOut;
    logic [15:0] aluFinal;
    logic [15:0] newPC;
    logic [15:0] addPC;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] exp_q = '0;

    execute_unit dut (
        .clk      (clk),
        .rst      (rst),
        .inA      (cur.inA),
        .inB      (cur.inB),
        .invA     (cur.invA),
        .invB     (cur.invB),
        .Cin      (cur.Cin),
        .aluOp    (cur.aluOp),
        .brchSig  (cur.brchSig),
        .incPC    (cur.incPC),
        .imm8     (cur.imm8),
        .imm11    (cur.imm11),
        .immSrc   (cur.immSrc),
        .SLBIsel  (cur.SLBIsel),
        .aluJmp   (cur.aluJmp),
        .jalSel   (cur.jalSel),
        .sOpSel   (cur.sOpSel),
        .aluOut   (aluOut),
        .aluFinal (aluFinal),
        .newPC    (newPC),
        .addPC    (addPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {aluOut, aluFinal, newPC, addPC} computed from the rules directly
    function automatic logic [63:0] model(input vec_t v);
        logic [15:0] a, b, r, comp, jmp, npc, apc, fin;
        logic [16:0] s17;
        logic        zf, sf, of, cf, cond;
        int          n, tot;
        a  = v.invA ? ~v.inA : v.inA;
        b  = v.invB ? ~v.inB : v.inB;
        n  = int'(b[3:0]);
        of = 1'b0;
        cf = 1'b0;
        r  = a;
        case (v.aluOp)
            4'd0: for (int k = 0; k < n; k++) r = {r[14:0], r[15]};
            4'd1: for (int k = 0; k < n; k++) r = {r[14:0], 1'b0};
            4'd2: for (int k = 0; k < n; k++) r = {r[0], r[15:1]};
            4'd3: for (int k = 0; k < n; k++) r = {1'b0, r[15:1]};
            4'd4: begin
                s17 = 17'(a) + 17'(b) + 17'(v.Cin);
                r   = s17[15:0];
                cf  = s17[16];
                tot = int'($signed(a)) + int'($signed(b)) + int'(v.Cin);
                of  = (tot > 32767) || (tot < -32768);
            end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = b;
            4'd9: r = (a * 16'd256) + (b % 16'd256);
            4'd10: for (int k = 0; k < 16; k++) r[k] = a[15-k];
            default: r = a;
        endcase
        zf = (r == 16'd0);
        sf = r[15];
        case (v.brchSig)
            3'd0: cond = 1'b0;
            3'd1: cond = zf;
            3'd2: cond = !zf;
            3'd3: cond = sf;
            3'd4: cond = !sf;
            3'd5: cond = sf ^ of;
            3'd6: cond = (sf ^ of) | zf;
            default: cond = cf;
        endcase
        comp = (v.SLBIsel ? r : v.incPC) + (v.immSrc ? v.imm11 : v.imm8);
        jmp  = cond ? comp : v.incPC;
        apc  = v.jalSel ? v.incPC : jmp;
        npc  = v.SLBIsel ? v.incPC : (v.aluJmp ? r : jmp);
        fin  = v.sOpSel ? 16'(cond) : r;
        return {r, fin, npc, apc};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= '0;
        else     exp_q <= model(cur);
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("model aluOut",   aluOut,   exp_q[63:48]);
        check("model aluFinal", aluFinal, exp_q[47:32]);
        check("model newPC",    newPC,    exp_q[31:16]);
        check("model addPC",    addPC,    exp_q[15:0]);
    end

    // mask bits: [3]=aluOut [2]=aluFinal [1]=newPC [0]=addPC
    task automatic check_lit(input string tag, input logic [63:0] e, input logic [3:0] mask);
        if (mask[3]) check({tag, " aluOut"},   aluOut,   e[63:48]);
        if (mask[2]) check({tag, " aluFinal"}, aluFinal, e[47:32]);
        if (mask[1]) check({tag, " newPC"},    newPC,    e[31:16]);
        if (mask[0]) check({tag, " addPC"},    addPC,    e[15:0]);
    endtask

    task automatic run_vec(input string tag, input vec_t v, input logic [63:0] e,
                           input logic [3:0] mask);
        cur = v;
        @(posedge clk);
        @(negedge clk);
        check_lit(tag, e, mask);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic ia, input logic ib, input logic ci,
                                input logic [2:0] br, input logic sop);
        vec_t v;
        v         = '0;
        v.aluOp   = op;
        v.inA     = a;
        v.inB     = b;
        v.invA    = ia;
        v.invB    = ib;
        v.Cin     = ci;
        v.brchSig = br;
        v.sOpSel  = sop;
        return v;
    endfunction

    vec_t v;

    initial begin
        cur = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_lit("reset", 64'h0, 4'hF);
        rst = 1'b0;

        v = mk(4'b0100, 16'h7FFF, 16'h0001, 0, 0, 0, 3'b101, 1);
        run_vec("add_ovf", v, {16'h8000, 16'h0000, 32'h0}, 4'b1100);

        v = mk(4'b0100, 16'h0005, 16'h0003, 1, 0, 1, 3'b011, 1);
        run_vec("sub_neg", v, {16'hFFFE, 16'h0001, 32'h0}, 4'b1100);

        v = mk(4'b0100, 16'h0000, 16'h0000, 0, 0, 0, 3'b001, 0);
        v.incPC = 16'h0010; v.imm8 = 16'h0004;
        run_vec("br_taken", v, {32'h0, 16'h0014, 16'h0014}, 4'b0011);
        v.brchSig = 3'b010;
        run_vec("br_not", v, {32'h0, 16'h0010, 16'h0010}, 4'b0011);

        v = mk(4'b0100, 16'h0100, 16'h0002, 0, 0, 0, 3'b000, 0);
        v.aluJmp = 1; v.jalSel = 1; v.incPC = 16'h0020;
        run_vec("jalr", v, {32'h0, 16'h0102, 16'h0020}, 4'b0011);

        v = mk(4'b1001, 16'h0012, 16'h0034, 0, 0, 0, 3'b000, 0);
        v.SLBIsel = 1; v.incPC = 16'h0040;
        run_vec("slbi", v, {16'h1234, 16'h1234, 16'h0040, 16'h0040}, 4'hF);
        v.aluOp = 4'b0000; v.inA = 16'h8001; v.inB = 16'h0001;
        run_vec("rol", v, {16'h0003, 16'h0003, 16'h0040, 16'h0040}, 4'hF);

        run_vec("ror", mk(4'b0010, 16'h0001, 16'h0001, 0, 0, 0, 0, 0), {16'h8000, 48'h0}, 4'b1000);
        run_vec("sll15", mk(4'b0001, 16'h8001, 16'h000F, 0, 0, 0, 0, 0), {16'h8000, 48'h0}, 4'b1000);
        run_vec("srl0", mk(4'b0011, 16'h8000, 16'h0000, 0, 0, 0, 0, 0), {16'h8000, 48'h0}, 4'b1000);
        run_vec("xor", mk(4'b0111, 16'hFFFF, 16'h0F0F, 0, 1, 0, 0, 0), {16'h0F0F, 48'h0}, 4'b1000);
        run_vec("and", mk(4'b0101, 16'h1234, 16'h00FF, 0, 0, 0, 0, 0), {16'h0034, 48'h0}, 4'b1000);
        run_vec("brev", mk(4'b1010, 16'h0001, 16'h0000, 0, 0, 0, 0, 0), {16'h8000, 48'h0}, 4'b1000);
        run_vec("passb", mk(4'b1000, 16'h0000, 16'h5555, 0, 1, 0, 0, 0), {16'hAAAA, 48'h0}, 4'b1000);
        run_vec("undef", mk(4'b1111, 16'h1357, 16'h0000, 0, 0, 0, 0, 0), {16'h1357, 48'h0}, 4'b1000);
        run_vec("carry", mk(4'b0100, 16'hFFFF, 16'h0001, 0, 0, 0, 3'b111, 1),
                {16'h0000, 16'h0001, 32'h0}, 4'b1100);
        run_vec("le", mk(4'b0100, 16'h0003, 16'h0005, 0, 1, 1, 3'b110, 1),
                {16'hFFFE, 16'h0001, 32'h0}, 4'b1100);
        run_vec("cf_nonadd", mk(4'b0110, 16'hFFFF, 16'hFFFF, 0, 0, 0, 3'b111, 1),
                {16'hFFFF, 16'h0000, 32'h0}, 4'b1100);

        v = mk(4'b0100, 16'h0100, 16'h0000, 0, 0, 0, 3'b000, 0);
        v.SLBIsel = 1; v.aluJmp = 1; v.incPC = 16'h0040;
        run_vec("slbi_prio", v, {16'h0100, 16'h0100, 16'h0040, 16'h0040}, 4'hF);

        v = mk(4'b1000, 16'h0000, 16'h0200, 0, 0, 0, 3'b100, 0);
        v.SLBIsel = 1; v.incPC = 16'h0040; v.imm11 = 16'h0010; v.immSrc = 1;
        run_vec("slbi_br", v, {16'h0200, 16'h0200, 16'h0040, 16'h0210}, 4'hF);

        // Sweep every opcode over a few operand patterns; model-checked only
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 3; s++) begin
                v = mk(4'(op), 16'hA5C3 ^ 16'(s * 16'h1111), 16'(op * 3 + s * 7),
                       s[0], s[1], op[0], 3'(op + s), op[1]);
                v.incPC = 16'h0100 + 16'(op); v.imm8 = 16'hFFF0; v.imm11 = 16'h0400;
                v.immSrc = s[0]; v.SLBIsel = (op == 9); v.aluJmp = s[1]; v.jalSel = op[2];
                cur = v;
                @(negedge clk);
            end
        end

        // Mid-stream asynchronous reset, then recovery on the first edge
        v = mk(4'b0110, 16'h00F0, 16'h0F00, 0, 0, 0, 3'b000, 0);
        v.incPC = 16'h0100;
        cur = v;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_lit("async_rst", 64'h0, 4'hF);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_lit("post_rst", {16'h0FF0, 16'h0FF0, 16'h0100, 16'h0100}, 4'hF);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-high reset, with the ports named clk and rst.
REQ-002 The following ports SHALL be provided (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous active-high reset.
- inA, inB, in, 16 each: ALU operands.
- invA, invB, in, 1 each: invert the corresponding operand before the ALU.
- Cin, in, 1: adder carry-in.
- aluOp, in, 4: ALU operation select.
- brchSig, in, 3: condition select.
- incPC, in, 16: PC+2.
- imm8, imm11, in, 16 each: pre-extended displacements.
- immSrc, in, 1: 1 selects imm11, 0 selects imm8.
- SLBIsel, in, 1: use ALU result as the PC-adder base and force newPC=incPC.
- aluJmp, in, 1: register-indirect jump.
- jalSel, in, 1: link; addPC=incPC.
- sOpSel, in, 1: set-op; aluFinal={15'b0, cond}.
- aluOut, aluFinal, newPC, addPC, out, 16 each: registered results.

Function
REQ-003 A' = invA ? ~inA : inA and B' = invB ? ~inB : inB; all ALU operations SHALL use A' and B'.
REQ-004 aluOp encoding SHALL be as follows (shift amount = B'[3:0]; all results 16 bits; codes not listed output A'):
- 0000 rotate left; 0001 shift left logical; 0010 rotate right; 0011 shift right logical.
- 0100 A'+B'+Cin; 0101 AND; 0110 OR; 0111 XOR.
- 1000 pass B'; 1001 {A'[7:0], B'[7:0]}; 1010 bit-reverse A'.
REQ-005 The add SHALL be built as a 16-bit carry-lookahead adder (4-bit CLA groups) that produces sum, Cout and signed overflow.
REQ-006 Flags SHALL come from the current combinational ALU result:
- zf = (result == 0).
- sf = result[15].
- of = signed two's-complement overflow of the add, 0 for non-add ops.
- cf = adder carry-out, 0 for non-add ops.
REQ-007 cond SHALL be selected by brchSig: 000→0; 001→zf; 010→!zf; 011→sf; 100→!sf; 101→sf^of; 110→(sf^of)|zf; 111→cf.
REQ-008 The PC adder SHALL compute compPC = (SLBIsel ? ALU result : incPC) + (immSrc ? imm11 : imm8), modulo 2^16, with carry-in 0 and carry-out discarded, using the same CLA.
REQ-009 The next-state values SHALL be:
- jmpPC = cond ? compPC : incPC.
- addPC_d = jalSel ? incPC : jmpPC.
- newPC_d = SLBIsel ? incPC : (aluJmp ? ALU result : jmpPC).
- aluFinal_d = sOpSel ? {15'b0, cond} : ALU result.
- aluOut_d = ALU result.
REQ-010 All four outputs SHALL be registered on the rising edge of clk, giving exactly one cycle of latency from input to output, with no enable and a new result every cycle.
REQ-011 Arithmetic SHALL wrap silently, and overflow SHALL affect only the of flag and cond.
REQ-012 When SLBIsel and aluJmp are both 1, SLBIsel SHALL take priority in newPC.
REQ-013 jalSel SHALL affect addPC only and SHALL leave newPC unchanged.

Reset
REQ-014 While rst=1, aluOut, aluFinal, newPC and addPC SHALL be 16'h0000 immediately, independent of clk.
REQ-015 On release of rst, the first rising edge SHALL capture the current inputs.
REQ-016 Asserting rst mid-stream SHALL discard the pending result, and the outputs SHALL return to 0 without waiting for a clock edge.

Verification
REQ-017 Scenario: assert rst asynchronously mid-cycle with nonzero inputs → all outputs read 0x0000 before the next edge; deassert, one edge → outputs reflect the inputs.
REQ-018 Scenario: aluOp=0100, inA=0x7FFF, inB=0x0001, Cin=0, brchSig=101, sOpSel=1 → one cycle later aluOut=0x8000, aluFinal=0x0000 (sf=1, of=1).
REQ-019 Scenario: aluOp=0100, inA=0x0005, invA=1, Cin=1, inB=0x0003, brchSig=011, sOpSel=1 → aluOut=0xFFFE, aluFinal=0x0001.
REQ-020 Scenario: aluOp=0100, inA=inB=0, brchSig=001, incPC=0x0010, imm8=0x0004, immSrc=0 → newPC=0x0014, addPC=0x0014; the same with brchSig=010 → newPC=addPC=0x0010.
REQ-021 Scenario: aluJmp=1, jalSel=1, aluOp=0100, inA=0x0100, inB=0x0002, incPC=0x0020, brchSig=000 → newPC=0x0102, addPC=0x0020.
REQ-022 Scenario: SLBIsel=1, aluOp=1001, inA=0x0012, inB=0x0034, incPC=0x0040 → aluOut=0x1234, newPC=0x0040; aluOp=0000, inA=0x8001, inB=0x0001 → aluOut=0x0003.
